// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle between a board-level SPI master and spi_slave_regs.
interface spi_slave_regs_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_slave_regs.sv
// Oversampled SPI slave (any CPOL/CPHA) in front of a bank of LED brightness
// registers: write, same-frame read-back, abort and address-range error pulses.
module spi_slave_regs #(
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int LED_COUNT  = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int BR_WIDTH   = 8
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  spi_slave_regs_if.slave               spi,
  output logic [ADDR_WIDTH-1:0]         o_led_addr,
  output logic [BR_WIDTH-1:0]           o_led_br_lvl,
  output logic                          o_wr_valid,
  output logic [LED_COUNT*BR_WIDTH-1:0] o_br_all,
  output logic                          o_frame_err,
  output logic                          o_addr_err
);
  localparam int FRAME_BITS = 1 + ADDR_WIDTH + BR_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_DATA = 2'd2, ST_DONE = 2'd3} state_e;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < LED_COUNT);
  endfunction

  logic [2:0]                    sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d;
  logic [1:0]                    mosi_sync_q, mosi_sync_d;
  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              bit_cnt_q, bit_cnt_d;
  logic                          rw_q, rw_d, miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d, led_addr_q, led_addr_d;
  logic [BR_WIDTH-1:0]           data_q, data_d, tx_q, tx_d, led_br_q, led_br_d;
  logic [LED_COUNT*BR_WIDTH-1:0] br_all_q, br_all_d;
  logic                          wr_valid_q, wr_valid_d, frame_err_q, frame_err_d, addr_err_q, addr_err_d;

  logic                  sclk_rise_s, sclk_fall_s, lead_s, trail_s, sample_s, shift_s;
  logic                  cs_rise_s, cs_fall_s, mosi_s;
  logic [ADDR_WIDTH-1:0] addr_nxt_s;
  logic [BR_WIDTH-1:0]   data_nxt_s, rd_val_s;

  // Edge decode of the synchronised pins and next-state for the whole block.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi.sclk};
    cs_sync_d   = {cs_sync_q[1:0], spi.cs};
    mosi_sync_d = {mosi_sync_q[0], spi.mosi};
    sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
    lead_s      = (CPOL == 0) ? sclk_rise_s : sclk_fall_s;
    trail_s     = (CPOL == 0) ? sclk_fall_s : sclk_rise_s;
    sample_s    = (CPHA == 0) ? lead_s : trail_s;
    shift_s     = (CPHA == 0) ? trail_s : lead_s;
    cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];
    cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
    mosi_s      = mosi_sync_q[1];
    addr_nxt_s  = ADDR_WIDTH'({addr_q, mosi_s});
    data_nxt_s  = BR_WIDTH'({data_q, mosi_s});

    // Out-of-range addresses match no register and read back as zero.
    rd_val_s = {BR_WIDTH{1'b0}};
    for (int i = 0; i < LED_COUNT; i++) begin
      rd_val_s = (int'(addr_nxt_s) == i) ? br_all_q[i*BR_WIDTH +: BR_WIDTH] : rd_val_s;
    end

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    miso_oe_d   = ~cs_sync_q[1];
    br_all_d    = br_all_q;
    led_addr_d  = led_addr_q;
    led_br_d    = led_br_q;
    wr_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    addr_err_d  = 1'b0;

    case (state_q)
      ST_CMD: begin
        if (sample_s) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(0)) begin
            rw_d = mosi_s;
          end else begin
            addr_d = addr_nxt_s;
          end
          if (bit_cnt_q == CNT_W'(ADDR_WIDTH)) begin
            state_d = ST_DATA;
            if (!rw_q) begin
              tx_d       = rd_val_s;
              addr_err_d = ~addr_ok(addr_nxt_s);
            end else begin
              tx_d = {BR_WIDTH{1'b0}};
            end
          end else begin
            state_d = ST_CMD;
          end
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (sample_s) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          data_d    = data_nxt_s;
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            state_d = ST_DONE;
            miso_d  = 1'b0;
            if (rw_q && addr_ok(addr_q)) begin
              for (int i = 0; i < LED_COUNT; i++) begin
                br_all_d[i*BR_WIDTH +: BR_WIDTH] = (int'(addr_q) == i) ? data_nxt_s
                                                                         : br_all_q[i*BR_WIDTH +: BR_WIDTH];
              end
              led_addr_d = addr_q;
              led_br_d   = data_nxt_s;
              wr_valid_d = 1'b1;
            end else begin
              addr_err_d = rw_q;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else if (shift_s && !rw_q) begin
          miso_d = tx_q[BR_WIDTH-1];
          tx_d   = tx_q << 1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_IDLE: state_d = ST_IDLE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    // The sample above is evaluated first, so a cs rise on the final sample is a clean end.
    if (cs_rise_s) begin
      if ((state_d == ST_CMD) || (state_d == ST_DATA)) begin
        frame_err_d = 1'b1;
        addr_err_d  = 1'b0;
      end else begin
        frame_err_d = 1'b0;
      end
      state_d = ST_IDLE;
      miso_d  = 1'b0;
    end else begin
      miso_d = miso_d;
    end

    if (cs_fall_s) begin
      state_d   = ST_CMD;
      bit_cnt_d = CNT_W'(0);
      rw_d      = 1'b0;
      addr_d    = {ADDR_WIDTH{1'b0}};
      data_d    = {BR_WIDTH{1'b0}};
      tx_d      = {BR_WIDTH{1'b0}};
      miso_d    = 1'b0;
    end else begin
      bit_cnt_d = bit_cnt_d;
    end
  end

  // All state and registered outputs.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= (CPOL != 0) ? 3'b111 : 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= CNT_W'(0);
      rw_q        <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      data_q      <= {BR_WIDTH{1'b0}};
      tx_q        <= {BR_WIDTH{1'b0}};
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      br_all_q    <= {(LED_COUNT*BR_WIDTH){1'b0}};
      led_addr_q  <= {ADDR_WIDTH{1'b0}};
      led_br_q    <= {BR_WIDTH{1'b0}};
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      br_all_q    <= br_all_d;
      led_addr_q  <= led_addr_d;
      led_br_q    <= led_br_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign spi.miso     = miso_q;
  assign spi.miso_oe  = miso_oe_q;
  assign o_led_addr   = led_addr_q;
  assign o_led_br_lvl = led_br_q;
  assign o_wr_valid   = wr_valid_q;
  assign o_br_all     = br_all_q;
  assign o_frame_err  = frame_err_q;
  assign o_addr_err   = addr_err_q;
endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: five instances (four SPI modes, plus LED_COUNT=3)
// driven by a bit-banged master and checked against a register-bank model.
module tb_spi_slave_regs;
  localparam int NDUT = 5;
  localparam logic [NDUT-1:0] P_CPOL = 5'b01100;
  localparam logic [NDUT-1:0] P_CPHA = 5'b01010;

  logic sysclk;
  logic rst_n;
  logic [NDUT-1:0] sclk_v, cs_v, mosi_v;
  logic [NDUT-1:0] miso_v, miso_oe_v, wr_v, aerr_v, ferr_v;
  logic [1:0]  led_addr_v [NDUT];
  logic [7:0]  led_lvl_v  [NDUT];
  logic [31:0] br_all_v   [NDUT];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_en  = 1'b0;
  int  c_wr   [NDUT] = '{default: 0};
  int  c_aerr [NDUT] = '{default: 0};
  int  c_ferr [NDUT] = '{default: 0};
  int  m_reg  [NDUT][4];
  int  m_addr [NDUT];
  int  m_lvl  [NDUT];

  initial sysclk = 1'b0;
  always #4 sysclk = ~sysclk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int LC = (k == 4) ? 3 : 4;
    spi_slave_regs_if sif ();
    logic [LC*8-1:0] br_w;
    assign sif.sclk     = sclk_v[k];
    assign sif.cs       = cs_v[k];
    assign sif.mosi     = mosi_v[k];
    assign miso_v[k]    = sif.miso;
    assign miso_oe_v[k] = sif.miso_oe;
    assign br_all_v[k]  = 32'(br_w);
    spi_slave_regs #(
      .CPOL(P_CPOL[k] ? 1 : 0), .CPHA(P_CPHA[k] ? 1 : 0),
      .LED_COUNT(LC), .ADDR_WIDTH(2), .BR_WIDTH(8)
    ) u_dut (
      .sysclk(sysclk), .rst_n(rst_n), .spi(sif.slave),
      .o_led_addr(led_addr_v[k]), .o_led_br_lvl(led_lvl_v[k]),
      .o_wr_valid(wr_v[k]), .o_br_all(br_w),
      .o_frame_err(ferr_v[k]), .o_addr_err(aerr_v[k])
    );
  end

  function automatic int lc_of(input int k);
    return (k == 4) ? 3 : 4;
  endfunction

  function automatic logic [31:0] exp_br(input int k);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < lc_of(k); i++) v = v | (32'(m_reg[k][i]) << (8 * i));
    return v;
  endfunction

  function automatic void chk(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 4; i++) m_reg[k][i] = 0;
      m_addr[k] = 0;
      m_lvl[k]  = 0;
    end
  endfunction

  // Pulse counting, and steady-state comparison of every instance against the model.
  always @(negedge sysclk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (wr_v[k])   c_wr[k]++;
      if (aerr_v[k]) c_aerr[k]++;
      if (ferr_v[k]) c_ferr[k]++;
      if (chk_en) begin
        chk(k, "idle_br_all",    64'(br_all_v[k]),   64'(exp_br(k)));
        chk(k, "idle_led_addr",  64'(led_addr_v[k]), 64'(m_addr[k]));
        chk(k, "idle_led_lvl",   64'(led_lvl_v[k]),  64'(m_lvl[k]));
        chk(k, "idle_miso",      64'(miso_v[k]),     64'd0);
        chk(k, "idle_miso_oe",   64'(miso_oe_v[k]),  64'd0);
        chk(k, "idle_wr_valid",  64'(wr_v[k]),       64'd0);
        chk(k, "idle_addr_err",  64'(aerr_v[k]),     64'd0);
        chk(k, "idle_frame_err", 64'(ferr_v[k]),     64'd0);
      end
    end
  end

  task automatic half_period();
    repeat (4) @(negedge sysclk);
  endtask

  task automatic xfer(input int k, input bit rw, input int addr, input int data, input int nbits,
                      input int extra, input bit keep_cs, output int rd);
    logic [10:0] frame;
    bit cpol, cpha;
    frame = {rw, 2'(addr), 8'(data)};
    cpol  = P_CPOL[k];
    cpha  = P_CPHA[k];
    rd    = 0;
    @(negedge sysclk);
    sclk_v[k] = cpol;
    cs_v[k]   = 1'b0;
    half_period();
    chk(k, "miso_oe_cs_low", 64'(miso_oe_v[k]), 64'd1);
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        mosi_v[k] = frame[10-b];
        half_period();
      end else begin
        sclk_v[k] = ~cpol;
        mosi_v[k] = frame[10-b];
        half_period();
      end
      if (b >= 3 && !rw) rd = (rd << 1) | int'(miso_v[k]);
      else chk(k, "miso_quiet", 64'(miso_v[k]), 64'd0);
      if (!cpha) begin
        sclk_v[k] = ~cpol;
        half_period();
        sclk_v[k] = cpol;
      end else begin
        sclk_v[k] = cpol;
        half_period();
      end
    end
    if (!keep_cs) begin
      half_period();
      for (int e = 0; e < extra; e++) begin
        sclk_v[k] = ~cpol;
        half_period();
        sclk_v[k] = cpol;
        half_period();
      end
      cs_v[k]   = 1'b1;
      mosi_v[k] = 1'b0;
    end
  endtask

  task automatic run_frame(input int k, input bit rw, input int addr, input int data, input int nbits,
                           input int extra, output int rd);
    int w0, a0, f0, e_wr, e_ae, e_fe, e_rd;
    bit in_r, complete;
    chk_en = 1'b0;
    w0 = c_wr[k];
    a0 = c_aerr[k];
    f0 = c_ferr[k];
    xfer(k, rw, addr, data, nbits, extra, 1'b0, rd);
    repeat (8) @(negedge sysclk);
    in_r     = (addr < lc_of(k));
    complete = (nbits == 11);
    e_wr = 0; e_ae = 0; e_fe = 0; e_rd = 0;
    if (!complete) begin
      e_fe = 1;
      if (!rw && nbits >= 3 && !in_r) e_ae = 1;
    end else if (rw) begin
      if (in_r) begin
        e_wr = 1;
        m_reg[k][addr] = data;
        m_addr[k] = addr;
        m_lvl[k]  = data;
      end else begin
        e_ae = 1;
      end
    end else begin
      e_rd = in_r ? m_reg[k][addr] : 0;
      e_ae = in_r ? 0 : 1;
    end
    chk(k, "wr_valid_pulses",  64'(c_wr[k] - w0),   64'(e_wr));
    chk(k, "addr_err_pulses",  64'(c_aerr[k] - a0), 64'(e_ae));
    chk(k, "frame_err_pulses", 64'(c_ferr[k] - f0), 64'(e_fe));
    if (complete && !rw) chk(k, "read_data", 64'(rd), 64'(e_rd));
    chk_en = 1'b1;
    repeat (4) @(negedge sysclk);
  endtask

  initial begin
    int rd;
    model_reset();
    rst_n  = 1'b0;
    sclk_v = P_CPOL;
    cs_v   = '1;
    mosi_v = '0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk(k, "reset_br_all",   64'(br_all_v[k]),  64'd0);
      chk(k, "reset_wr_valid", 64'(wr_v[k]),      64'd0);
      chk(k, "reset_miso_oe",  64'(miso_oe_v[k]), 64'd0);
    end
    repeat (5) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (6) @(negedge sysclk);
    chk_en = 1'b1;

    // Mode 0 write then read-back.
    run_frame(0, 1'b1, 2, 'hA5, 11, 0, rd);
    chk(0, "t1_br_all",   64'(br_all_v[0]),   64'h00A50000);
    chk(0, "t1_led_addr", 64'(led_addr_v[0]), 64'd2);
    chk(0, "t1_led_lvl",  64'(led_lvl_v[0]),  64'hA5);
    run_frame(0, 1'b0, 2, 'hC3, 11, 0, rd);
    chk(0, "t2_read_a5", 64'(rd), 64'hA5);

    // Abort after 6 bits, then a clean write.
    run_frame(0, 1'b1, 1, 'hFF, 6, 0, rd);
    chk(0, "t3_br_unchanged", 64'(br_all_v[0]), 64'h00A50000);
    run_frame(0, 1'b1, 1, 'h3C, 11, 0, rd);
    chk(0, "t3_br_all", 64'(br_all_v[0]), 64'h00A53C00);

    // LED_COUNT=3: address 3 is out of range for write and read.
    run_frame(4, 1'b1, 3, 'hFF, 11, 0, rd);
    chk(4, "t4_br_all", 64'(br_all_v[4]), 64'd0);
    run_frame(4, 1'b0, 3, 'hC3, 11, 0, rd);
    chk(4, "t4_read_zero", 64'(rd), 64'd0);

    // Remaining SPI modes, with surplus sclk cycles before cs rises.
    for (int k = 1; k <= 3; k++) begin
      run_frame(k, 1'b1, 0, 'h5A, 11, 3, rd);
      run_frame(k, 1'b0, 0, 'h00, 11, 3, rd);
      chk(k, "t5_read_5a", 64'(rd), 64'h5A);
    end

    // Reset in the middle of a write's data phase.
    run_frame(0, 1'b1, 0, 'h11, 11, 0, rd);
    chk(0, "t6_br_all_pre", 64'(br_all_v[0]), 64'h00A53C11);
    chk_en = 1'b0;
    xfer(0, 1'b1, 1, 'h99, 6, 0, 1'b1, rd);
    #2;
    rst_n = 1'b0;
    #1;
    chk(0, "t6_rst_br_all",   64'(br_all_v[0]),   64'd0);
    chk(0, "t6_rst_led_addr", 64'(led_addr_v[0]), 64'd0);
    chk(0, "t6_rst_led_lvl",  64'(led_lvl_v[0]),  64'd0);
    chk(0, "t6_rst_miso_oe",  64'(miso_oe_v[0]),  64'd0);
    chk(0, "t6_rst_miso",     64'(miso_v[0]),     64'd0);
    model_reset();
    cs_v[0]   = 1'b1;
    mosi_v[0] = 1'b0;
    sclk_v[0] = P_CPOL[0];
    repeat (4) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (6) @(negedge sysclk);
    chk_en = 1'b1;
    run_frame(0, 1'b1, 3, 'h77, 11, 0, rd);
    chk(0, "t6_br_all_post", 64'(br_all_v[0]), 64'h77000000);
    run_frame(0, 1'b0, 3, 'h00, 11, 0, rd);
    chk(0, "t6_read_77", 64'(rd), 64'h77);

    chk_en = 1'b0;
    @(negedge sysclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
